// File: rtl/pwr_mon_pkg.sv
// Shared types for the power-good supervisor: per-rail FSM state encoding
// and the fault codes reported to the power sequencer.
package pwr_mon_pkg;

    typedef enum logic [2:0] {
        OFF       = 3'd0,
        RAMP_UP,
        ON,
        RAMP_DOWN,
        FAULT
    } rail_state_t;

    localparam logic [1:0] FLT_NONE  = 2'b00;
    localparam logic [1:0] FLT_UP_TO = 2'b01;
    localparam logic [1:0] FLT_LOST  = 2'b10;
    localparam logic [1:0] FLT_DN_TO = 2'b11;

endpackage

// File: rtl/pwr_rail_fsm.sv
// One monitored rail: power-good synchronizer, ramp/loss supervision FSM,
// and a one-cycle fault pulse carrying the fault code on FAULT entry.
module pwr_rail_fsm
    import pwr_mon_pkg::*;
#(
    parameter int               CNT_W       = 20,
    parameter logic [CNT_W-1:0] UP_TIMEOUT  = 20'd50000,
    parameter logic [CNT_W-1:0] DN_TIMEOUT  = 20'd50000,
    parameter logic [7:0]       GLITCH_FILT = 8'd4
) (
    input  logic       fsm_clk,
    input  logic       reset,
    input  logic       rail_en,
    input  logic       rail_pg,
    input  logic       fault_clr,
    output logic       rail_ok,
    output logic       flt_pulse,
    output logic [1:0] flt_code
);

    rail_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       gcnt_q, gcnt_d;
    logic [1:0]       sync_q, sync_d;
    logic             pulse_q, pulse_d;
    logic [1:0]       code_q, code_d;
    logic             pg_s;

    assign sync_d = {sync_q[0], rail_pg};
    assign pg_s   = sync_q[1];

    // NOTE: every always_comb output gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gcnt_d  = gcnt_q;
        pulse_d = 1'b0;
        code_d  = FLT_NONE;
        case (state_q)
            OFF: begin
                if (rail_en) begin
                    state_d = RAMP_UP;
                    cnt_d   = '0;
                end
            end
            RAMP_UP: begin
                if (!rail_en) begin
                    state_d = RAMP_DOWN;
                    cnt_d   = '0;
                end else if (pg_s) begin
                    state_d = ON;
                    gcnt_d  = '0;
                end else if (cnt_q == UP_TIMEOUT) begin
                    state_d = FAULT;
                    pulse_d = 1'b1;
                    code_d  = FLT_UP_TO;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ON: begin
                if (!rail_en) begin
                    state_d = RAMP_DOWN;
                    cnt_d   = '0;
                end else if (!pg_s) begin
                    // Only a run of GLITCH_FILT consecutive low samples is a loss.
                    gcnt_d = gcnt_q + 8'd1;
                    if (gcnt_q + 8'd1 == GLITCH_FILT) begin
                        state_d = FAULT;
                        pulse_d = 1'b1;
                        code_d  = FLT_LOST;
                    end
                end else begin
                    gcnt_d = '0;
                end
            end
            RAMP_DOWN: begin
                if (rail_en) begin
                    state_d = RAMP_UP;
                    cnt_d   = '0;
                end else if (!pg_s) begin
                    state_d = OFF;
                end else if (cnt_q == DN_TIMEOUT) begin
                    state_d = FAULT;
                    pulse_d = 1'b1;
                    code_d  = FLT_DN_TO;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            FAULT: begin
                if (fault_clr) begin
                    state_d = OFF;
                end
            end
            default: state_d = OFF;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of the others.
    always_ff @(posedge fsm_clk) begin
        if (!reset) begin
            state_q <= OFF;
            cnt_q   <= '0;
            gcnt_q  <= '0;
            sync_q  <= '0;
            pulse_q <= 1'b0;
            code_q  <= FLT_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gcnt_q  <= gcnt_d;
            sync_q  <= sync_d;
            pulse_q <= pulse_d;
            code_q  <= code_d;
        end
    end

    assign rail_ok   = (state_q == ON);
    assign flt_pulse = pulse_q;
    assign flt_code  = code_q;

endmodule

// File: rtl/pwr_rail_monitor.sv
// Power-good supervisor: N_RAILS rail monitors plus a first-fault latch that
// drives a level power-off request back to the power sequencer.
module pwr_rail_monitor
    import pwr_mon_pkg::*;
#(
    parameter int               N_RAILS     = 6,
    parameter int               CNT_W       = 20,
    parameter logic [CNT_W-1:0] UP_TIMEOUT  = 20'd50000,
    parameter logic [CNT_W-1:0] DN_TIMEOUT  = 20'd50000,
    parameter logic [7:0]       GLITCH_FILT = 8'd4
) (
    input  logic               fsm_clk,
    input  logic               reset,
    input  logic [N_RAILS-1:0] rail_en,
    input  logic [N_RAILS-1:0] rail_pg,
    input  logic               fault_clr,
    output logic [N_RAILS-1:0] rail_ok,
    output logic               all_good,
    output logic               fault,
    output logic [1:0]         fault_code,
    output logic [2:0]         fault_rail,
    output logic               pwr_off_req
);

    logic [N_RAILS-1:0] flt_pulse_w;
    logic [1:0]         flt_code_w [N_RAILS];

    for (genvar i = 0; i < N_RAILS; i++) begin : g_rail
        pwr_rail_fsm #(
            .CNT_W      (CNT_W),
            .UP_TIMEOUT (UP_TIMEOUT),
            .DN_TIMEOUT (DN_TIMEOUT),
            .GLITCH_FILT(GLITCH_FILT)
        ) u_rail (
            .fsm_clk  (fsm_clk),
            .reset    (reset),
            .rail_en  (rail_en[i]),
            .rail_pg  (rail_pg[i]),
            .fault_clr(fault_clr),
            .rail_ok  (rail_ok[i]),
            .flt_pulse(flt_pulse_w[i]),
            .flt_code (flt_code_w[i])
        );
    end

    logic       fault_q, fault_d;
    logic [1:0] code_q, code_d;
    logic [2:0] rail_q, rail_d;
    logic       all_good_q, all_good_d;
    logic [1:0] pick_code;
    logic [2:0] pick_rail;

    // Lowest pulsing index wins; scanning downward leaves it as the last write.
    always_comb begin
        pick_code = FLT_NONE;
        pick_rail = '0;
        for (int i = N_RAILS - 1; i >= 0; i--) begin
            if (flt_pulse_w[i]) begin
                pick_code = flt_code_w[i];
                pick_rail = 3'(i);
            end
        end
    end

    // A new fault coinciding with fault_clr takes precedence over the clear.
    always_comb begin
        fault_d = fault_q;
        code_d  = code_q;
        rail_d  = rail_q;
        if ((|flt_pulse_w) && (!fault_q || fault_clr)) begin
            fault_d = 1'b1;
            code_d  = pick_code;
            rail_d  = pick_rail;
        end else if (fault_clr && fault_q) begin
            fault_d = 1'b0;
            code_d  = FLT_NONE;
            rail_d  = '0;
        end
        all_good_d = (&rail_ok) && !fault_d;
    end

    always_ff @(posedge fsm_clk) begin
        if (!reset) begin
            fault_q    <= 1'b0;
            code_q     <= FLT_NONE;
            rail_q     <= '0;
            all_good_q <= 1'b0;
        end else begin
            fault_q    <= fault_d;
            code_q     <= code_d;
            rail_q     <= rail_d;
            all_good_q <= all_good_d;
        end
    end

    assign fault       = fault_q;
    assign fault_code  = code_q;
    assign fault_rail  = rail_q;
    assign pwr_off_req = fault_q;
    assign all_good    = all_good_q;

endmodule

// File: tb/tb_pwr_rail_monitor.sv
// Directed bench for pwr_rail_monitor with short timeouts: a vector table for
// power-up, glitch filtering and clear, then hand sequences for the corners.
module tb_pwr_rail_monitor;

    logic       fsm_clk;
    logic       reset;
    logic [5:0] rail_en;
    logic [5:0] rail_pg;
    logic       fault_clr;
    logic [5:0] rail_ok;
    logic       all_good;
    logic       fault;
    logic [1:0] fault_code;
    logic [2:0] fault_rail;
    logic       pwr_off_req;

    int total = 0;
    int bad   = 0;

    pwr_rail_monitor #(
        .N_RAILS    (6),
        .CNT_W      (20),
        .UP_TIMEOUT (20'd100),
        .DN_TIMEOUT (20'd100),
        .GLITCH_FILT(8'd4)
    ) dut (
        .fsm_clk    (fsm_clk),
        .reset      (reset),
        .rail_en    (rail_en),
        .rail_pg    (rail_pg),
        .fault_clr  (fault_clr),
        .rail_ok    (rail_ok),
        .all_good   (all_good),
        .fault      (fault),
        .fault_code (fault_code),
        .fault_rail (fault_rail),
        .pwr_off_req(pwr_off_req)
    );

    initial fsm_clk = 1'b0;
    always #5 fsm_clk = ~fsm_clk;

    typedef struct {
        int unsigned hold;
        logic [5:0]  en;
        logic [5:0]  pg;
        logic        clr;
        logic [5:0]  ok;
        logic        ag;
        logic        flt;
        logic [1:0]  code;
        logic [2:0]  frail;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int unsigned hold, logic [5:0] en, logic [5:0] pg,
                                logic clr, logic [5:0] ok, logic ag, logic flt,
                                logic [1:0] code, logic [2:0] frail);
        vec_t v;
        v.hold = hold; v.en = en; v.pg = pg; v.clr = clr; v.ok = ok;
        v.ag = ag; v.flt = flt; v.code = code; v.frail = frail;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_flt(input string tag, input logic f, input logic [1:0] code,
                           input logic [2:0] frail);
        check({tag, ".fault"}, 32'(fault), 32'(f));
        check({tag, ".code"}, 32'(fault_code), 32'(code));
        check({tag, ".rail"}, 32'(fault_rail), 32'(frail));
        check({tag, ".pwr_off_req"}, 32'(pwr_off_req), 32'(f));
    endtask

    // Inputs change 1 time unit after the edge; outputs are sampled there too.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge fsm_clk);
            #1;
        end
    endtask

    initial begin
        reset     = 1'b0;
        rail_en   = '0;
        rail_pg   = '0;
        fault_clr = 1'b0;
        step(2);
        check("reset.rail_ok", 32'(rail_ok), 32'h0);
        check("reset.all_good", 32'(all_good), 32'h0);
        chk_flt("reset", 1'b0, 2'b00, 3'd0);
        reset = 1'b1;

        // Normal power-up: rail r enabled, pg 10 cycles later, ON 13 cycles after enable.
        for (int r = 0; r < 6; r++) begin
            logic [5:0] prev;
            logic [5:0] cur;
            prev = 6'((1 << r) - 1);
            cur  = 6'((1 << (r + 1)) - 1);
            vecs.push_back(mk(10,  cur, prev, 1'b0, prev, 1'b0, 1'b0, 2'b00, 3'd0));
            vecs.push_back(mk(2,   cur, cur,  1'b0, prev, 1'b0, 1'b0, 2'b00, 3'd0));
            vecs.push_back(mk(1,   cur, cur,  1'b0, cur,  1'b0, 1'b0, 2'b00, 3'd0));
            vecs.push_back(mk(1,   cur, cur,  1'b0, cur,  r == 5, 1'b0, 2'b00, 3'd0));
            vecs.push_back(mk(486, cur, cur,  1'b0, cur,  r == 5, 1'b0, 2'b00, 3'd0));
        end
        // Glitch of 3 low cycles is filtered; 4 low cycles is a rail loss on rail 0.
        vecs.push_back(mk(3,  6'h3f, 6'h3e, 1'b0, 6'h3f, 1'b1, 1'b0, 2'b00, 3'd0));
        vecs.push_back(mk(10, 6'h3f, 6'h3f, 1'b0, 6'h3f, 1'b1, 1'b0, 2'b00, 3'd0));
        vecs.push_back(mk(4,  6'h3f, 6'h3e, 1'b0, 6'h3f, 1'b1, 1'b0, 2'b00, 3'd0));
        vecs.push_back(mk(1,  6'h3f, 6'h3f, 1'b0, 6'h3f, 1'b1, 1'b0, 2'b00, 3'd0));
        vecs.push_back(mk(1,  6'h3f, 6'h3f, 1'b0, 6'h3e, 1'b1, 1'b0, 2'b00, 3'd0));
        vecs.push_back(mk(1,  6'h3f, 6'h3f, 1'b0, 6'h3e, 1'b0, 1'b1, 2'b10, 3'd0));
        // Clear, then rail 0 re-ramps because its enable is still high.
        vecs.push_back(mk(1,  6'h3f, 6'h3f, 1'b1, 6'h3e, 1'b0, 1'b0, 2'b00, 3'd0));
        vecs.push_back(mk(1,  6'h3f, 6'h3f, 1'b0, 6'h3e, 1'b0, 1'b0, 2'b00, 3'd0));
        vecs.push_back(mk(1,  6'h3f, 6'h3f, 1'b0, 6'h3f, 1'b0, 1'b0, 2'b00, 3'd0));
        vecs.push_back(mk(1,  6'h3f, 6'h3f, 1'b0, 6'h3f, 1'b1, 1'b0, 2'b00, 3'd0));

        foreach (vecs[i]) begin
            rail_en   = vecs[i].en;
            rail_pg   = vecs[i].pg;
            fault_clr = vecs[i].clr;
            for (int c = 0; c < int'(vecs[i].hold); c++) begin
                step(1);
                if (c < int'(vecs[i].hold) - 1)
                    check($sformatf("vec%0d.fault_hold", i), 32'(fault), 32'(vecs[i].flt));
            end
            check($sformatf("vec%0d.rail_ok", i), 32'(rail_ok), 32'(vecs[i].ok));
            check($sformatf("vec%0d.all_good", i), 32'(all_good), 32'(vecs[i].ag));
            chk_flt($sformatf("vec%0d", i), vecs[i].flt, vecs[i].code, vecs[i].frail);
        end
        fault_clr = 1'b0;

        // Down timeout on rail 5: enable dropped, pg stays high.
        rail_en = 6'h1f;
        step(1);
        check("dn.rail_ok", 32'(rail_ok), 32'h1f);
        step(101);
        chk_flt("dn.before", 1'b0, 2'b00, 3'd0);
        step(1);
        chk_flt("dn.to", 1'b1, 2'b11, 3'd5);
        fault_clr = 1'b1;
        step(1);
        fault_clr = 1'b0;
        chk_flt("dn.clr", 1'b0, 2'b00, 3'd0);
        rail_en = 6'h3f;
        step(2);
        check("dn.reup", 32'(rail_ok), 32'h3f);
        // Down ramp completes in time: pg drops 50 cycles after enable.
        rail_en = 6'h1f;
        step(50);
        rail_pg = 6'h1f;
        step(3);
        check("dn.off.rail_ok", 32'(rail_ok), 32'h1f);
        step(100);
        chk_flt("dn.off", 1'b0, 2'b00, 3'd0);

        // Reset from a live state, then up timeout on rail 2.
        reset   = 1'b0;
        rail_en = '0;
        rail_pg = '0;
        step(1);
        check("rst2.rail_ok", 32'(rail_ok), 32'h0);
        check("rst2.all_good", 32'(all_good), 32'h0);
        reset   = 1'b1;
        rail_en = 6'h04;
        step(102);
        chk_flt("up.before", 1'b0, 2'b00, 3'd0);
        step(1);
        chk_flt("up.to", 1'b1, 2'b01, 3'd2);
        rail_en   = '0;
        fault_clr = 1'b1;
        step(1);
        fault_clr = 1'b0;
        chk_flt("up.clr", 1'b0, 2'b00, 3'd0);

        // Rails 1 and 4 time out together; rail 3 later; rail 0 coincides with a clear.
        rail_en = 6'h12;
        step(10);
        rail_en = 6'h1a;
        step(20);
        rail_en = 6'h1b;
        step(73);
        chk_flt("sim.first", 1'b1, 2'b01, 3'd1);
        step(15);
        chk_flt("sim.held", 1'b1, 2'b01, 3'd1);
        step(14);
        chk_flt("sim.preclr", 1'b1, 2'b01, 3'd1);
        fault_clr = 1'b1;
        step(1);
        chk_flt("sim.clr_vs_new", 1'b1, 2'b01, 3'd0);
        rail_en = '0;
        step(1);
        fault_clr = 1'b0;
        chk_flt("sim.cleared", 1'b0, 2'b00, 3'd0);

        // Reset during RAMP_UP aborts silently; the rail restarts with a fresh count.
        rail_en = 6'h01;
        step(50);
        reset = 1'b0;
        step(1);
        reset = 1'b1;
        check("rr.rail_ok", 32'(rail_ok), 32'h0);
        chk_flt("rr.reset", 1'b0, 2'b00, 3'd0);
        step(102);
        chk_flt("rr.before", 1'b0, 2'b00, 3'd0);
        step(1);
        chk_flt("rr.to", 1'b1, 2'b01, 3'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pwr_rail_monitor.md
# pwr_rail_monitor

Power-good supervisor on the receiving end of the power-sequencer rail-enable interface. It watches the six per-step rail enables and the matching regulator power-good feedback, checks every rail ramps up and down within bounded time and stays good while enabled, and latches the first fault. On a fault it raises a level power-off request that feeds the sequencer's `en_pwr_off` input.

## Interface
Parameters:
- `N_RAILS`, 6: number of monitored rails; enables and power-good are bit-indexed 0..N_RAILS-1 (bit 0 = step1).
- `UP_TIMEOUT`, 20'd50000: max cycles from enable rise to synchronized power-good high.
- `DN_TIMEOUT`, 20'd50000: max cycles from enable fall to synchronized power-good low.
- `GLITCH_FILT`, 8'd4: consecutive low cycles of synchronized power-good on an ON rail that count as rail loss.
- `CNT_W`, 20: timeout counter width.

Ports:
- `fsm_clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-low reset.
- `rail_en`  in  N_RAILS  rail enables from the sequencer (`pwr_init_step1..6`), synchronous to `fsm_clk`.
- `rail_pg`  in  N_RAILS  regulator power-good pins, asynchronous.
- `fault_clr`  in  1  single-cycle pulse; clears latched fault.
- `rail_ok`  out  N_RAILS  per-rail: rail in ON state.
- `all_good`  out  1  every rail ON and no fault latched.
- `fault`  out  1  sticky fault flag.
- `fault_code`  out  2  01 up-timeout, 10 rail lost, 11 down-timeout, 00 none.
- `fault_rail`  out  3  index of first faulted rail.
- `pwr_off_req`  out  1  level request to sequencer; equals `fault`.

## Operation
- `rail_pg` passes through a 2-FF synchronizer per bit (reset 0); all decisions use the synchronized value `pg_s`.
- Per-rail FSM, states OFF, RAMP_UP, ON, RAMP_DOWN, FAULT; per-rail counter `cnt` (CNT_W bits) and glitch counter `gcnt` (8 bits).
- OFF: `rail_en`=1 -> RAMP_UP, cnt<=0. `pg_s` ignored.
- RAMP_UP: `rail_en`=0 -> RAMP_DOWN, cnt<=0. Else `pg_s`=1 -> ON, gcnt<=0. Else cnt==UP_TIMEOUT -> FAULT (code 01). Else cnt+1.
- ON: `rail_en`=0 -> RAMP_DOWN, cnt<=0. Else `pg_s`=0: gcnt+1; gcnt+1==GLITCH_FILT -> FAULT (code 10). `pg_s`=1 -> gcnt<=0.
- RAMP_DOWN: `rail_en`=1 -> RAMP_UP, cnt<=0. Else `pg_s`=0 -> OFF. Else cnt==DN_TIMEOUT -> FAULT (code 11). Else cnt+1.
- FAULT: held until `fault_clr`; then -> OFF (re-enters RAMP_UP next cycle if `rail_en` still high).
- Each rail emits a one-cycle `flt_pulse` with its code on the FAULT-entry transition.
- Aggregator: if `fault`=0 and any `flt_pulse`, latch fault<=1, fault_code, fault_rail = lowest pulsing index. Later pulses ignored while `fault`=1.
- `fault_clr` with `fault`=1 clears fault, code, rail to 0. Same-cycle `fault_clr` and new `flt_pulse`: the new fault wins and is latched.
- Counters saturate by construction (compare before increment); no wrap.

## Timing
- Reset (`reset`=0 at a `fsm_clk` edge): all FSMs OFF, counters 0, synchronizers 0; `rail_ok`=0, `all_good`=0, `fault`=0, `fault_code`=00, `fault_rail`=0, `pwr_off_req`=0. Reset mid-ramp aborts without a fault.
- `rail_pg` pin rise -> `pg_s` after 2 edges -> ON on the next edge; `rail_ok` high 3 cycles after the pin, with the rail enabled.
- Up timeout: enable seen high at edge E0 -> RAMP_UP at E1; FAULT at E1+UP_TIMEOUT+1 if `pg_s` never high; `fault`/`pwr_off_req` high one edge later.
- Rail loss: FAULT on the GLITCH_FILT-th consecutive low `pg_s` sample; `fault` high one edge later.
- `all_good` is registered: high one cycle after the last rail reaches ON.
- `fault_clr`: outputs clear on the next edge; the rail FSM leaves FAULT on the same edge.

## Structure
- Shared package `pwr_mon_pkg`: `rail_state_t` enum (OFF=3'd0, RAMP_UP, ON, RAMP_DOWN, FAULT) and fault-code constants `FLT_NONE`, `FLT_UP_TO`, `FLT_LOST`, `FLT_DN_TO`.
- Sub-module `pwr_rail_fsm`: one rail, containing its synchronizer, FSM, cnt, gcnt and flt_pulse/code. Instantiated N_RAILS times via generate. The top holds the first-fault latch and priority encoder.

## Test plan
- Normal up (UP_TIMEOUT=100): rails enabled in order 500 cycles apart, each `rail_pg` 10 cycles after its enable -> each `rail_ok` 13 cycles after its enable, `all_good`=1 one cycle after rail 5 ON, `fault`=0 throughout.
- Up timeout: rail 2 enabled, `rail_pg[2]` held low -> `fault`=1, code 01, `fault_rail`=2, `pwr_off_req`=1, at 102 cycles after enable sampled (+1 latch).
- Glitch filter (GLITCH_FILT=4): all ON, `rail_pg[0]` low 3 cycles -> no fault, `rail_ok[0]` stays 1; then low 4 cycles -> code 10, `fault_rail`=0.
- Down timeout (DN_TIMEOUT=100): drop `rail_en[5]`, keep `rail_pg[5]` high -> code 11, `fault_rail`=5; `rail_pg` low after 50 cycles instead -> OFF, no fault.
- Simultaneous faults on rails 1 and 4 in the same cycle -> `fault_rail`=1. A second fault while latched leaves outputs unchanged. `fault_clr` -> all fault outputs 0 next cycle. `fault_clr` coincident with a new pulse -> the new fault is latched.
- `reset` low for one cycle during RAMP_UP -> all outputs 0, no fault. With `rail_en` still high, the rail restarts RAMP_UP.
